// File: rtl/sft_reg_sequencer_if.sv
// Job request / result handshake bundle between a job producer and sft_reg_sequencer.
// The master modport is the producer/consumer side; slave is the sequencer.
interface sft_reg_sequencer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_dir;
  logic [CNT_W-1:0] in_count;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output in_dir,
    output in_count,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_dir,
    input  in_count,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/sft_reg_sequencer.sv
// Sequences a downstream universal shift register: parallel load, N shifts in one
// direction, one settle cycle, then capture of the register contents as a result.
module sft_reg_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  sft_reg_sequencer_if.slave bus,
  output logic [1:0]       sel,
  output logic [WIDTH-1:0] pin,
  input  logic [WIDTH-1:0] pout,
  output logic             busy
);

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_RIGHT = 2'b01;
  localparam logic [1:0] SEL_LEFT  = 2'b10;
  localparam logic [1:0] SEL_LOAD  = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SHIFT  = 3'd2,
    SETTLE = 3'd3,
    OUT    = 3'd4
  } state_t;

  state_t           state_r;
  logic [1:0]       sel_r;
  logic [WIDTH-1:0] pin_r;
  logic [WIDTH-1:0] data_r;
  logic             dir_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_valid_r;
  logic             busy_r;

  // Shifting past the register width only ever yields zero fill, so clamp there.
  function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] c);
    if (32'(c) > 32'(WIDTH)) begin
      eff_count = CNT_W'(WIDTH);
    end else begin
      eff_count = c;
    end
  endfunction

  function automatic logic [1:0] shift_sel(input logic dir);
    if (dir) begin
      shift_sel = SEL_LEFT;
    end else begin
      shift_sel = SEL_RIGHT;
    end
  endfunction

  // Gated by rst so a job can never be taken on a reset edge.
  assign bus.in_ready  = (state_r == IDLE) && !rst;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign sel           = sel_r;
  assign pin           = pin_r;
  assign busy          = busy_r;

  // Job FSM with all shift-register controls and result outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      sel_r       <= SEL_HOLD;
      pin_r       <= '0;
      data_r      <= '0;
      dir_r       <= 1'b0;
      cnt_r       <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.in_valid) begin
            data_r  <= bus.in_data;
            dir_r   <= bus.in_dir;
            cnt_r   <= eff_count(bus.in_count);
            pin_r   <= bus.in_data;
            sel_r   <= SEL_LOAD;
            busy_r  <= 1'b1;
            state_r <= LOAD;
          end else begin
            sel_r   <= SEL_HOLD;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end

        LOAD: begin
          pin_r <= data_r;
          if (cnt_r != '0) begin
            sel_r   <= shift_sel(dir_r);
            state_r <= SHIFT;
          end else begin
            sel_r   <= SEL_HOLD;
            state_r <= SETTLE;
          end
        end

        SHIFT: begin
          pin_r <= data_r;
          cnt_r <= cnt_r - CNT_W'(1);
          if (cnt_r == CNT_W'(1)) begin
            sel_r   <= SEL_HOLD;
            state_r <= SETTLE;
          end else begin
            sel_r   <= shift_sel(dir_r);
            state_r <= SHIFT;
          end
        end

        // The last shift has landed in the register by now; sample it.
        SETTLE: begin
          sel_r       <= SEL_HOLD;
          out_data_r  <= pout;
          out_valid_r <= 1'b1;
          state_r     <= OUT;
        end

        OUT: begin
          sel_r <= SEL_HOLD;
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= IDLE;
          end else begin
            out_valid_r <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= OUT;
          end
        end

        default: begin
          sel_r       <= SEL_HOLD;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          cnt_r       <= '0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sft_reg_sequencer.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and
// compares on each result; a zero-fill shift register model closes the loop.
module tb_sft_reg_sequencer;
  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk;
  logic             rst;
  logic [1:0]       sel;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] pout;
  logic             busy;
  logic [WIDTH-1:0] sr;
  int               cyc;
  int               checks;
  int               errors;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               acc;
    int               lat;
    logic [15:0]      sels;
    int               nsel;
    int               hold;
  } exp_t;

  exp_t sb[$];

  sft_reg_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  sft_reg_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .sel  (sel),
    .pin  (pin),
    .pout (pout),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Zero-fill universal shift register model.
  always @(posedge clk) begin
    case (sel)
      2'b11:   sr <= pin;
      2'b01:   sr <= {1'b0, sr[WIDTH-1:1]};
      2'b10:   sr <= {sr[WIDTH-2:0], 1'b0};
      default: sr <= sr;
    endcase
  end
  assign pout = sr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_job(input logic [WIDTH-1:0] d, input logic dir, input logic [CNT_W-1:0] c,
                        input logic [WIDTH-1:0] ed, input logic [15:0] es, input int ns,
                        input int lat, input int hold, input bit push);
    bit   ok;
    exp_t e;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      ok = (bus.in_ready === 1'b1);
    end
    chk("in_ready_wait", 32'(ok), 32'd1);
    if (ok) begin
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_dir   = dir;
      bus.in_count = c;
      @(posedge clk);
      #1;
      e.data = ed;
      e.acc  = cyc;
      e.lat  = lat;
      e.sels = es;
      e.nsel = ns;
      e.hold = hold;
      if (push) sb.push_back(e);
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      bus.in_count = '0;
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      done = (sb.size() == 0) && (busy === 1'b0);
    end
    chk("drain", 32'(done), 32'd1);
  endtask

  // Monitor: captures the sel sequence of each job and checks every result.
  initial begin
    exp_t        e;
    int          hold_left;
    bit          in_out;
    logic [15:0] seq;
    int          nseq;
    bus.out_ready = 1'b0;
    in_out    = 1'b0;
    seq       = '0;
    nseq      = 0;
    hold_left = 0;
    e.data    = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.out_ready = 1'b0;
        in_out = 1'b0;
        seq    = '0;
        nseq   = 0;
      end else if (bus.out_valid === 1'b1) begin
        if (!in_out) begin
          in_out = 1'b1;
          chk("result_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("out_data", 32'(bus.out_data), 32'(e.data));
            chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
            chk("sel_seq", 32'(seq), 32'(e.sels));
            chk("sel_len", 32'(nseq), 32'(e.nsel));
            hold_left = e.hold;
          end else begin
            hold_left = 0;
          end
          seq  = '0;
          nseq = 0;
        end else begin
          chk("out_data_stable", 32'(bus.out_data), 32'(e.data));
          chk("sel_in_out", 32'(sel), 32'd0);
        end
        if (hold_left == 0) begin
          bus.out_ready = 1'b1;
        end else begin
          bus.out_ready = 1'b0;
          hold_left--;
        end
      end else begin
        bus.out_ready = 1'b0;
        in_out = 1'b0;
        if (busy === 1'b1) begin
          seq = {seq[13:0], sel};
          nseq++;
        end
      end
    end
  end

  // Stimulus.
  initial begin
    int  n;
    bit  seen;
    cyc = 0;
    checks = 0;
    errors = 0;
    sr = '0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_dir   = 1'b0;
    bus.in_count = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_pin", 32'(pin), 32'd0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

    do_job(4'b1010, 1'b0, 3'd1, 4'b0101, 16'h0034, 3, 4, 0, 1'b1);
    do_job(4'b1010, 1'b1, 3'd2, 4'b1000, 16'h00E8, 4, 5, 1, 1'b1);
    do_job(4'b0110, 1'b0, 3'd0, 4'b0110, 16'h000C, 2, 3, 0, 1'b1);
    do_job(4'b1111, 1'b0, 3'd7, 4'b0000, 16'h0D54, 6, 7, 0, 1'b1);
    do_job(4'b1001, 1'b1, 3'd3, 4'b1000, 16'h03A8, 5, 6, 0, 1'b1);
    do_job(4'b1011, 1'b0, 3'd3, 4'b0001, 16'h0354, 5, 6, 0, 1'b1);
    do_job(4'b0111, 1'b1, 3'd5, 4'b0000, 16'h0EA8, 6, 7, 0, 1'b1);
    drain();

    // Stalled consumer: in_valid pulses while OUT must be ignored.
    do_job(4'b1100, 1'b1, 3'd1, 4'b1000, 16'h0038, 3, 4, 5, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      seen = (bus.out_valid === 1'b1);
    end
    chk("out_valid_seen", 32'(seen), 32'd1);
    n = 0;
    while (bus.out_valid === 1'b1 && n < 20) begin
      chk("in_ready_in_out", 32'(bus.in_ready), 32'd0);
      bus.in_valid = n[0];
      bus.in_data  = 4'b1111;
      bus.in_count = 3'd0;
      @(negedge clk);
      n++;
    end
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    chk("out_cycles", 32'(n), 32'd6);
    chk("in_ready_after_hs", 32'(bus.in_ready), 32'd1);
    chk("busy_after_hs", 32'(busy), 32'd0);
    drain();

    // Reset during the second SHIFT cycle aborts the job silently.
    do_job(4'b1010, 1'b0, 3'd3, 4'b0000, 16'h0000, 0, 0, 0, 1'b0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("sel_shift2", 32'(sel), 32'd1);
    rst = 1'b1;
    #1;
    chk("in_ready_during_rst", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("abort_sel", 32'(sel), 32'd0);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_abort", 32'(bus.in_ready), 32'd1);
    do_job(4'b0101, 1'b1, 3'd1, 4'b1010, 16'h0038, 3, 4, 0, 1'b1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
